// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the pipeline (port 0) has priority, and the
// DMA/debug port (port 1) is forced through after STARVE_LIMIT denied cycles.
module dmem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int DEPTH_WORDS  = 512
) (
  input  logic             clk,
  input  logic             rst,
  // Port 0: pipeline MEM stage
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] adr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             stall0,
  output logic [WIDTH-1:0] rdata0,
  output logic             rvalid0,
  // Port 1: DMA / debug
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] adr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             err1,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid1,
  // Single-port data memory
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_P0,
    GRANT_P1
  } grant_e;

  localparam logic [3:0]       LIMIT = 4'(STARVE_LIMIT);
  localparam logic [WIDTH-1:0] DEPTH = WIDTH'(DEPTH_WORDS);

  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic             rvalid0_q, rvalid1_q, err1_q;
  logic [WIDTH-1:0] rdata0_q, rdata1_q;

  grant_e grant;
  logic   force1;
  logic   oor1;

  assign force1 = req1 && (starve_cnt_q == LIMIT);
  assign oor1   = (adr1 >> 2) >= DEPTH;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    grant        = GRANT_NONE;
    starve_cnt_d = 4'd0;
    if (req1 && (!req0 || force1)) begin
      grant = GRANT_P1;
    end else if (req0) begin
      grant = GRANT_P0;
    end
    // A waiting port-1 request counts up until it is forced through.
    if (req1 && grant != GRANT_P1) begin
      starve_cnt_d = (starve_cnt_q < LIMIT) ? starve_cnt_q + 4'd1 : LIMIT;
    end
  end

  assign gnt0   = (grant == GRANT_P0);
  assign gnt1   = (grant == GRANT_P1);
  assign stall0 = req0 && !gnt0;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    unique case (grant)
      GRANT_P0: begin
        mem_adr   = adr0;
        mem_wdata = wdata0;
        mem_read  = !we0;
        mem_write = we0;
      end
      GRANT_P1: begin
        mem_adr   = adr1;
        mem_wdata = wdata1;
        // Out-of-range port-1 accesses are granted but never reach memory.
        mem_read  = !we1 && !oor1;
        mem_write = we1 && !oor1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register sees the
  // pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= 4'd0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rvalid0_q    <= gnt0 && !we0;
      rvalid1_q    <= gnt1 && !we1 && !oor1;
      err1_q       <= gnt1 && oor1;
      if (gnt0 && !we0) begin
        rdata0_q <= mem_rdata;
      end
      if (gnt1 && !we1 && !oor1) begin
        rdata1_q <= mem_rdata;
      end
    end
  end

  assign rdata0  = rdata0_q;
  assign rvalid0 = rvalid0_q;
  assign rdata1  = rdata1_q;
  assign rvalid1 = rvalid1_q;
  assign err1    = err1_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data and address width of both requester ports and the memory port.
REQ-002 Parameter STARVE_LIMIT, default 4, legal range 1..15: consecutive denied cycles on port 1 before port 1 is forced through.
REQ-003 Parameter DEPTH_WORDS, default 512: number of words in the data memory; word index = adr>>2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 req0, we0  input  1 each  port 0 (pipeline MEM stage): access request and write enable (1 = write, 0 = read).
REQ-007 adr0, wdata0  input  WIDTH each  port 0 byte address and write data.
REQ-008 gnt0, stall0  output  1 each  port 0 grant this cycle; stall0 = req0 & ~gnt0, fed to the pipeline hazard logic.
REQ-009 rdata0  output  WIDTH, rvalid0  output  1  port 0 registered read data and one-cycle valid pulse.
REQ-010 req1, we1  input  1 each  port 1 (DMA/debug): access request and write enable.
REQ-011 adr1, wdata1  input  WIDTH each  port 1 byte address and write data.
REQ-012 gnt1, err1  output  1 each  port 1 grant this cycle; err1 = registered out-of-range error pulse.
REQ-013 rdata1  output  WIDTH, rvalid1  output  1  port 1 registered read data and valid pulse.
REQ-014 mem_read, mem_write  output  1 each; mem_adr, mem_wdata  output  WIDTH; mem_rdata  input  WIDTH  single-port data memory interface (combinational read, write on clk edge).

Function
REQ-015 At most one of gnt0/gnt1 is 1 in any cycle; both grants are combinational functions of the requests and the starvation counter.
REQ-016 Default priority is port 0: gnt0 = req0 unless a forced port-1 grant applies (REQ-018).
REQ-017 gnt1 = req1 & ~req0, or a forced grant; a request is accepted on the rising edge where its gnt is 1.
REQ-018 Forced grant: when starve_cnt == STARVE_LIMIT and req1 = 1, gnt1 = 1 and gnt0 = 0 for that cycle, regardless of req0.
REQ-019 starve_cnt, 4 bits: +1 on each edge where req1 & ~gnt1, saturating at STARVE_LIMIT; cleared to 0 on any edge where gnt1 = 1 or req1 = 0.
REQ-020 The memory port mirrors the granted port: mem_adr/mem_wdata from that port; mem_read = gnt & ~we; mem_write = gnt & we; with no grant, mem_read = mem_write = 0 and mem_adr = mem_wdata = 0.
REQ-021 Read latency is 1 cycle: on the accepting edge, mem_rdata is captured into that port's rdata register, and rvalid pulses high for exactly the following cycle.
REQ-022 rdata0/rdata1 hold their last captured value until the next read on the same port; writes do not change rdata or pulse rvalid.
REQ-023 Range check on port 1 only: when (adr1>>2) >= DEPTH_WORDS, gnt1 is still issued but mem_read = mem_write = 0, and err1 pulses for one cycle after the accepting edge with rvalid1 = 0.
REQ-024 Back-to-back grants to the same or alternating ports are permitted every cycle with no bubble.
REQ-025 Port 0 is never range-checked.
REQ-026 Port 0 requests that collide with a forced grant stall for exactly that one cycle.

Reset
REQ-027 While rst = 0: starve_cnt = 0, rdata0 = rdata1 = 0, rvalid0 = rvalid1 = 0, err1 = 0; grants and memory strobes remain combinational but rvalid pulses are suppressed.
REQ-028 Reset asserted mid-access drops the access: no rvalid or err pulse is produced for it after the release of reset.

Verification
REQ-029 Port 0 read only, adr0 = 0x10, mem[4] = 0xDEADBEEF -> gnt0 = 1, mem_read = 1, mem_adr = 0x10; next cycle rvalid0 = 1, rdata0 = 0xDEADBEEF.
REQ-030 Simultaneous reads, req0 = req1 = 1 held, STARVE_LIMIT = 4 -> gnt0 for 4 cycles, stall0 = 0; 5th cycle gnt1 = 1, stall0 = 1, starve_cnt returns to 0; 6th cycle gnt0 again.
REQ-031 Port 1 write, adr1 = 0x7D0 (word 500), wdata1 = 0x12345678, req0 = 0 -> mem_write = 1 for one cycle, no rvalid1; a subsequent port-0 read of 0x7D0 returns 0x12345678.
REQ-032 Port 1 read, adr1 = 0x800 (word 512) -> gnt1 = 1, mem_read = 0; next cycle err1 = 1, rvalid1 = 0, rdata1 unchanged.
REQ-033 Pull rst low on the accepting edge of a port-0 read -> starve_cnt = 0 and rvalid0 = 0 immediately; after release there is no rvalid0 pulse.
REQ-034 Alternating req0/req1 pulses every cycle -> grant every cycle, rvalid0 and rvalid1 alternate with 1-cycle latency, and starve_cnt never exceeds 1.
